// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo32 family: data width, read-latency modes,
// delivered-word counter width and the read-latency legality check.
package fifo_pkg;

    localparam int FIFO32_WIDTH = 32;
    localparam int FIFO32_DEPTH = 512;
    localparam int COUNT_W      = 16;

    typedef enum int {
        RLAT_FWFT = 0,
        RLAT_REG  = 1
    } rlatency_e;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [1:0]         occ_t;

    function automatic bit rlatencyLegal(input int rlat);
        return (rlat == int'(RLAT_FWFT)) || (rlat == int'(RLAT_REG));
    endfunction

endpackage

// File: rtl/fifo32_reader_buf.sv
// Two-entry in-order queue; head is a flop so the stream data is registered.
// Flush dominates, and a push is accepted when full only alongside a pop.
module fifo32_reader_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO32_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output occ_t             count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    occ_t             count_q, count_d;
    logic             popOk;
    logic             pushOk;

    assign popOk  = pop_i && (count_q != 2'd0);
    assign pushOk = push_i && ((count_q != 2'd2) || popOk);

    // Simultaneous pop and push shifts the tail forward and refills behind it.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (popOk && pushOk) begin
            if (count_q == 2'd1) begin
                head_d = wdata_i;
            end else begin
                head_d = tail_q;
                tail_d = wdata_i;
            end
        end else if (popOk) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end else if (pushOk) begin
            if (count_q == 2'd0) begin
                head_d = wdata_i;
            end else begin
                tail_d = wdata_i;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo32_reader.sv
// Drains a FWFT or registered-read FIFO into a valid/ready stream through a
// 2-entry buffer, counting every delivered word.
module fifo32_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO32_WIDTH,
    parameter int RLATENCY = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_pop,
    input  logic               i_empty,
    input  logic [WIDTH-1:0]   i_rdata,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic [COUNT_W-1:0] o_count
);

    if (!rlatencyLegal(RLATENCY)) begin : g_badRlatency
        $error("fifo32_reader: RLATENCY must be 0 or 1");
    end

    occ_t   bufCount;
    occ_t   reserved;
    logic   inFlight_q;
    logic   bufPush;
    logic   handshake;
    count_t delivered_q, delivered_d;

    assign o_valid   = (bufCount != 2'd0) && !rst;
    assign handshake = o_valid && i_ready;
    assign reserved  = bufCount + {1'b0, inFlight_q};

    // A pop at full reservation is allowed only when a slot frees at the same edge.
    assign o_pop = !i_empty && !i_flush && !rst &&
                   ((reserved < 2'd2) || ((reserved == 2'd2) && handshake));

    if (RLATENCY == int'(RLAT_REG)) begin : g_regRead
        always_ff @(posedge clk) begin
            if (rst || i_flush) begin
                inFlight_q <= 1'b0;
            end else begin
                inFlight_q <= o_pop;
            end
        end
        assign bufPush = inFlight_q;
    end else begin : g_fwftRead
        assign inFlight_q = 1'b0;
        assign bufPush    = o_pop;
    end

    fifo32_reader_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bufPush),
        .wdata_i (i_rdata),
        .pop_i   (handshake),
        .flush_i (i_flush),
        .head_o  (o_data),
        .count_o (bufCount)
    );

    // A handshake coinciding with a flush is discarded, so it is not counted.
    always_comb begin
        delivered_d = delivered_q;
        if (handshake && !i_flush) begin
            delivered_d = delivered_q + count_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delivered_q <= '0;
        end else begin
            delivered_q <= delivered_d;
        end
    end

    assign o_count = rst ? '0 : delivered_q;

endmodule

// File: tb/tb_fifo32_reader.sv
// Bench for fifo32_reader: a FWFT and a registered-read instance share stimulus,
// each fed by its own behavioural FIFO model.
module tb_fifo32_reader;
    import fifo_pkg::*;

    localparam int W    = 32;
    localparam int MEMD = 1 << 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          ready0 = 1'b0, ready1 = 1'b0;
    logic          force0 = 1'b0, force1 = 1'b0;
    logic          pop0, pop1, valid0, valid1, empty0, empty1;
    logic [W-1:0]  rdata0, rdata1, data0, data1;
    logic [W-1:0]  rdata1_q;
    logic [15:0]   count0, count1;

    logic [W-1:0]  mem0 [MEMD];
    logic [W-1:0]  mem1 [MEMD];
    logic [16:0]   wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
    logic [16:0]   exp0 = '0, exp1 = '0;

    int errors = 0, checks = 0;
    int popCnt0 = 0, popCnt1 = 0, underflows = 0;
    logic sbOn = 1'b0;
    logic holdPrev0 = 1'b0, holdPrev1 = 1'b0;
    logic [W-1:0] prevData0, prevData1;
    logic [W-1:0] got0 [$];
    logic [W-1:0] got1 [$];
    logic [W-1:0] seq = 32'h4000_0000;

    typedef struct {
        logic        ready;
        logic        pop0;
        logic        valid0;
        logic [31:0] data0;
        logic [15:0] cnt0;
        logic        pop1;
        logic        valid1;
        logic [31:0] data1;
        logic [15:0] cnt1;
    } vec_t;
    vec_t tbl [11];

    assign empty0 = (wp0 == rp0) || force0;
    assign empty1 = (wp1 == rp1) || force1;
    assign rdata0 = mem0[rp0];
    assign rdata1 = rdata1_q;

    fifo32_reader #(.WIDTH(W), .RLATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .o_pop(pop0), .i_empty(empty0), .i_rdata(rdata0),
        .i_flush(flush), .o_valid(valid0), .i_ready(ready0), .o_data(data0), .o_count(count0)
    );

    fifo32_reader #(.WIDTH(W), .RLATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .o_pop(pop1), .i_empty(empty1), .i_rdata(rdata1),
        .i_flush(flush), .o_valid(valid1), .i_ready(ready1), .o_data(data1), .o_count(count1)
    );

    // FIFO models: FWFT exposes the head directly, registered read returns it one edge later.
    always @(posedge clk) begin
        if (pop0) begin
            rp0     <= rp0 + 17'd1;
            popCnt0 <= popCnt0 + 1;
        end
        if (pop1) begin
            rp1      <= rp1 + 17'd1;
            rdata1_q <= mem1[rp1];
            popCnt1  <= popCnt1 + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Underflow watch, in-order scoreboard and hold-while-stalled checks.
    always @(negedge clk) begin
        if ((pop0 && empty0) || (pop1 && empty1)) underflows++;
        if (!sbOn) begin
            exp0 = rp0;
            exp1 = rp1;
        end else if (!rst && !flush) begin
            if (holdPrev0) begin
                checkOutput("hold0_valid", 32'(valid0), 32'd1);
                checkOutput("hold0_data", data0, prevData0);
            end
            if (holdPrev1) begin
                checkOutput("hold1_valid", 32'(valid1), 32'd1);
                checkOutput("hold1_data", data1, prevData1);
            end
            if (valid0 && ready0) begin
                checkOutput("sb0_data", data0, mem0[exp0]);
                exp0 = exp0 + 17'd1;
            end
            if (valid1 && ready1) begin
                checkOutput("sb1_data", data1, mem1[exp1]);
                exp1 = exp1 + 17'd1;
            end
        end
        holdPrev0 = sbOn && valid0 && !ready0 && !flush && !rst;
        holdPrev1 = sbOn && valid1 && !ready1 && !flush && !rst;
        prevData0 = data0;
        prevData1 = data1;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d);
        mem0[wp0] = d;
        wp0 = wp0 + 17'd1;
    endtask

    task automatic push1(input logic [31:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 17'd1;
    endtask

    task automatic pushBoth(input logic [31:0] d);
        push0(d);
        push1(d);
    endtask

    task automatic topUp();
        if ((wp0 - rp0) < 17'd4) begin
            push0(seq);
            seq = seq + 32'd1;
        end
        if ((wp1 - rp1) < 17'd4) begin
            push1(seq);
            seq = seq + 32'd1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ready0 = v.ready;
        ready1 = v.ready;
    endtask

    task automatic collectWords(input int n, input int budget);
        got0.delete();
        got1.delete();
        ready0 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < budget && (got0.size() < n || got1.size() < n); i++) begin
            @(negedge clk);
            if (valid0 && ready0) got0.push_back(data0);
            if (valid1 && ready1) got1.push_back(data1);
            nextCycle();
            ready0 = (got0.size() < n);
            ready1 = (got1.size() < n);
        end
        ready0 = 1'b0;
        ready1 = 1'b0;
    endtask

    task automatic checkWords(input string name, input logic [31:0] base, input int n);
        checkOutput({name, "_n0"}, 32'(got0.size()), 32'(n));
        checkOutput({name, "_n1"}, 32'(got1.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got0.size()) checkOutput($sformatf("%s_w0_%0d", name, i), got0[i], base + 32'(i));
            if (i < got1.size()) checkOutput($sformatf("%s_w1_%0d", name, i), got1[i], base + 32'(i));
        end
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base0, base1;

        // ready, pop0, valid0, data0, cnt0, pop1, valid1, data1, cnt1
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 16'd0, 1'b1, 1'b0, 32'h0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h1, 16'd0, 1'b1, 1'b0, 32'h0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h2, 16'd1, 1'b1, 1'b1, 32'h1, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h3, 16'd2, 1'b1, 1'b1, 32'h2, 16'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h4, 16'd3, 1'b1, 1'b1, 32'h3, 16'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h5, 16'd4, 1'b1, 1'b1, 32'h4, 16'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h6, 16'd5, 1'b1, 1'b1, 32'h5, 16'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h7, 16'd6, 1'b1, 1'b1, 32'h6, 16'd5};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h8, 16'd7, 1'b0, 1'b1, 32'h7, 16'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0, 16'd8, 1'b0, 1'b1, 32'h8, 16'd7};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 16'd8, 1'b0, 1'b0, 32'h0, 16'd8};

        repeat (3) nextCycle();
        for (int i = 1; i <= 8; i++) pushBoth(32'(i));

        // Reset holds everything quiet even with a non-empty FIFO.
        @(negedge clk);
        checkOutput("rst_pop0", 32'(pop0), 32'd0);
        checkOutput("rst_pop1", 32'(pop1), 32'd0);
        checkOutput("rst_valid0", 32'(valid0), 32'd0);
        checkOutput("rst_valid1", 32'(valid1), 32'd0);
        checkOutput("rst_count0", 32'(count0), 32'd0);
        checkOutput("rst_count1", 32'(count1), 32'd0);
        nextCycle();
        rst = 1'b0;

        // Back-to-back streaming of the preloaded words.
        for (int c = 0; c < 11; c++) begin
            applyStimulus(tbl[c]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_pop0", c), 32'(pop0), 32'(tbl[c].pop0));
            checkOutput($sformatf("vec%0d_valid0", c), 32'(valid0), 32'(tbl[c].valid0));
            checkOutput($sformatf("vec%0d_count0", c), 32'(count0), 32'(tbl[c].cnt0));
            checkOutput($sformatf("vec%0d_pop1", c), 32'(pop1), 32'(tbl[c].pop1));
            checkOutput($sformatf("vec%0d_valid1", c), 32'(valid1), 32'(tbl[c].valid1));
            checkOutput($sformatf("vec%0d_count1", c), 32'(count1), 32'(tbl[c].cnt1));
            if (tbl[c].valid0) checkOutput($sformatf("vec%0d_data0", c), data0, tbl[c].data0);
            if (tbl[c].valid1) checkOutput($sformatf("vec%0d_data1", c), data1, tbl[c].data1);
            nextCycle();
        end
        checkOutput("stream_pops0", 32'(popCnt0), 32'd8);
        checkOutput("stream_pops1", 32'(popCnt1), 32'd8);

        // Stalled consumer: only two words are taken and the head holds.
        ready0 = 1'b0;
        ready1 = 1'b0;
        base0 = popCnt0;
        base1 = popCnt1;
        for (int i = 0; i < 4; i++) pushBoth(32'h21 + 32'(i));
        repeat (10) nextCycle();
        @(negedge clk);
        checkOutput("stall_pops0", 32'(popCnt0 - base0), 32'd2);
        checkOutput("stall_pops1", 32'(popCnt1 - base1), 32'd2);
        checkOutput("stall_valid0", 32'(valid0), 32'd1);
        checkOutput("stall_valid1", 32'(valid1), 32'd1);
        checkOutput("stall_data0", data0, 32'h21);
        checkOutput("stall_data1", data1, 32'h21);
        nextCycle();
        collectWords(4, 20);
        checkWords("release", 32'h21, 4);

        // Flush with the buffer and the read pipeline loaded after a handshake.
        for (int i = 0; i < 5; i++) pushBoth(32'h31 + 32'(i));
        repeat (6) nextCycle();
        @(negedge clk);
        checkOutput("preflush_data0", data0, 32'h31);
        checkOutput("preflush_data1", data1, 32'h31);
        nextCycle();
        ready0 = 1'b1;
        ready1 = 1'b1;
        nextCycle();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_pop0", 32'(pop0), 32'd0);
        checkOutput("flush_pop1", 32'(pop1), 32'd0);
        checkOutput("flush_head0", data0, 32'h32);
        checkOutput("flush_head1", data1, 32'h32);
        nextCycle();
        flush = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        @(negedge clk);
        checkOutput("postflush_valid0", 32'(valid0), 32'd0);
        checkOutput("postflush_valid1", 32'(valid1), 32'd0);
        checkOutput("postflush_count0", 32'(count0), 32'd13);
        checkOutput("postflush_count1", 32'(count1), 32'd13);
        nextCycle();
        collectWords(2, 10);
        checkWords("resume", 32'h34, 2);
        @(negedge clk);
        checkOutput("resume_count0", 32'(count0), 32'd15);
        checkOutput("resume_count1", 32'(count1), 32'd15);
        nextCycle();

        // Run each counter up to 0xFFFF, then one more handshake wraps it.
        for (int i = 0; i < 70000; i++) begin
            topUp();
            ready0 = (count0 != 16'hFFFF);
            ready1 = (count1 != 16'hFFFF);
            if (!ready0 && !ready1) break;
            nextCycle();
        end
        ready0 = 1'b0;
        ready1 = 1'b0;
        nextCycle();
        topUp();
        @(negedge clk);
        checkOutput("max_count0", 32'(count0), 32'hFFFF);
        checkOutput("max_count1", 32'(count1), 32'hFFFF);
        checkOutput("max_valid0", 32'(valid0), 32'd1);
        checkOutput("max_valid1", 32'(valid1), 32'd1);
        nextCycle();
        ready0 = 1'b1;
        ready1 = 1'b1;
        topUp();
        nextCycle();
        topUp();
        @(negedge clk);
        checkOutput("wrap_count0", 32'(count0), 32'h0);
        checkOutput("wrap_count1", 32'(count1), 32'h0);
        nextCycle();
        topUp();
        nextCycle();
        topUp();

        // Reset in the middle of a running stream.
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_pop0", 32'(pop0), 32'd0);
        checkOutput("midrst_pop1", 32'(pop1), 32'd0);
        checkOutput("midrst_valid0", 32'(valid0), 32'd0);
        checkOutput("midrst_count1", 32'(count1), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("midrst2_valid0", 32'(valid0), 32'd0);
        checkOutput("midrst2_valid1", 32'(valid1), 32'd0);
        checkOutput("midrst2_count0", 32'(count0), 32'd0);
        checkOutput("midrst2_count1", 32'(count1), 32'd0);
        nextCycle();
        rst = 1'b0;
        sbOn = 1'b1;
        @(negedge clk);
        checkOutput("afterrst_pop0", 32'(pop0), 32'd1);
        checkOutput("afterrst_pop1", 32'(pop1), 32'd1);
        checkOutput("afterrst_valid0", 32'(valid0), 32'd0);
        checkOutput("afterrst_valid1", 32'(valid1), 32'd0);
        nextCycle();

        // Random availability and back-pressure against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            force0 = ($urandom_range(0, 3) == 0);
            force1 = ($urandom_range(0, 3) == 0);
            ready0 = ($urandom_range(0, 2) != 0);
            ready1 = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push0(seq);
                seq = seq + 32'd1;
            end
            if ($urandom_range(0, 1) == 1) begin
                push1(seq);
                seq = seq + 32'd1;
            end
            nextCycle();
        end
        force0 = 1'b0;
        force1 = 1'b0;
        ready0 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 400 && (exp0 != wp0 || exp1 != wp1); i++) nextCycle();
        checkOutput("drain_idx0", 32'(exp0), 32'(wp0));
        checkOutput("drain_idx1", 32'(exp1), 32'(wp1));
        checkOutput("underflows", 32'(underflows), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
